// File: rtl/calc_pkg.sv
// Shared definitions for the calculator round-robin scheduler: opcodes,
// FSM state encoding and the error-opcode classifier.
package calc_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_MOD  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_LAST = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opcodes past OP_LAST are unsupported; DIV/MOD need a nonzero divisor.
    function automatic logic is_err_op(input logic [3:0] op, input logic b_is_zero);
        logic err_v;
        if (op > OP_LAST) begin
            err_v = 1'b1;
        end else if (((op == OP_DIV) || (op == OP_MOD)) && b_is_zero) begin
            err_v = 1'b1;
        end else begin
            err_v = 1'b0;
        end
        return err_v;
    endfunction

endpackage

// File: rtl/calc_rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester that was not
// served last wins. Purely combinational.
module calc_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // Pick a winner among the valid requesters.
    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        case (valid)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant_idx = ~last_grant;
                grant     = last_grant ? 2'b01 : 2'b10;
            end
            default: begin
                grant     = 2'b00;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/calc_rr_scheduler.sv
// Shares one external calculator ALU between two requesters with round-robin
// arbitration, a single operation in flight and a registered, flagged result.
module calc_rr_scheduler
    import calc_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [3:0]         req0_op,
    input  logic [NBITS-1:0]   req0_a,
    input  logic [NBITS-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [3:0]         req1_op,
    input  logic [NBITS-1:0]   req1_a,
    input  logic [NBITS-1:0]   req1_b,
    output logic               rsp0_valid,
    input  logic               rsp0_ready,
    output logic               rsp1_valid,
    input  logic               rsp1_ready,
    output logic [2*NBITS-1:0] rsp_result,
    output logic               rsp_err,
    output logic [3:0]         alu_op,
    output logic [NBITS-1:0]   alu_a,
    output logic [NBITS-1:0]   alu_b,
    input  logic [2*NBITS-1:0] alu_result,
    output logic               busy,
    output logic [CNT_W-1:0]   ops_done
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               last_grant_r;
    logic               owner_r;
    logic [3:0]         op_r;
    logic [NBITS-1:0]   a_r;
    logic [NBITS-1:0]   b_r;
    logic [2*NBITS-1:0] result_r;
    logic               err_r;
    logic [CNT_W-1:0]   ops_done_r;
    logic [1:0]         grant_s;
    logic               grant_idx_s;
    logic               accept_s;
    logic               rsp_ready_s;

    calc_rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    assign accept_s    = (state_r == IDLE) && (grant_s != 2'b00) && !reset;
    assign rsp_ready_s = owner_r ? rsp1_ready : rsp0_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and request-side handshake.
    always_comb begin
        state_nxt_s = state_r;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    req0_ready  = grant_s[0];
                    req1_ready  = grant_s[1];
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (rsp_ready_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Command latch, result capture, grant history and completion counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            op_r         <= 4'd0;
            a_r          <= '0;
            b_r          <= '0;
            result_r     <= '0;
            err_r        <= 1'b0;
            ops_done_r   <= '0;
        end else begin
            if (accept_s) begin
                owner_r <= grant_idx_s;
                op_r    <= grant_idx_s ? req1_op : req0_op;
                a_r     <= grant_idx_s ? req1_a : req0_a;
                b_r     <= grant_idx_s ? req1_b : req0_b;
            end
            if (state_r == EXEC) begin
                if (is_err_op(op_r, (b_r == '0))) begin
                    result_r <= '0;
                    err_r    <= 1'b1;
                end else begin
                    result_r <= alu_result;
                    err_r    <= 1'b0;
                end
            end
            if ((state_r == RESP) && rsp_ready_s) begin
                last_grant_r <= owner_r;
                ops_done_r   <= ops_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // The ALU sees the latched command, so its inputs hold between operations.
    assign alu_op     = op_r;
    assign alu_a      = a_r;
    assign alu_b      = b_r;
    assign rsp_result = result_r;
    assign rsp_err    = err_r;
    assign rsp0_valid = (state_r == RESP) && !owner_r;
    assign rsp1_valid = (state_r == RESP) && owner_r;
    assign busy       = (state_r != IDLE);
    assign ops_done   = ops_done_r;

endmodule
